// File: rtl/cpu_pkg.sv
// Shared widths, fairness limit and FSM encoding for the operand fetch stage.
package cpu_pkg;

    localparam int CPU_REG_ID_LEN   = 4;
    localparam int CPU_REG_SIZE     = 64;
    localparam int CPU_STARVE_LIMIT = 4;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE   = 2'd0;
    localparam fetch_state_t ST_READ_A = 2'd1;
    localparam fetch_state_t ST_READ_B = 2'd2;
    localparam fetch_state_t ST_HOLD   = 2'd3;

    function automatic int streak_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Request, operand, writeback and register-file port bundle of the fetch stage.
interface operand_fetch_if
    import cpu_pkg::*;
#(
    parameter int REG_ID_LEN = CPU_REG_ID_LEN,
    parameter int REG_SIZE   = CPU_REG_SIZE
);
    logic                  req_valid;
    logic                  req_ready;
    logic [REG_ID_LEN-1:0] req_rs1;
    logic [REG_ID_LEN-1:0] req_rs2;
    logic                  req_use_rs2;
    logic                  op_valid;
    logic                  op_ready;
    logic [REG_SIZE-1:0]   op_a;
    logic [REG_SIZE-1:0]   op_b;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [REG_ID_LEN-1:0] wb_id;
    logic [REG_SIZE-1:0]   wb_value;
    logic [REG_ID_LEN-1:0] rf_id;
    logic                  rf_write;
    logic [REG_SIZE-1:0]   rf_value;
    logic                  rf_read;
    logic [REG_SIZE-1:0]   rf_out;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_use_rs2, op_ready,
               wb_valid, wb_id, wb_value, rf_out,
        output req_ready, op_valid, op_a, op_b, wb_ready,
               rf_id, rf_write, rf_value, rf_read
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_use_rs2, op_ready,
               wb_valid, wb_id, wb_value, rf_out,
        input  req_ready, op_valid, op_a, op_b, wb_ready,
               rf_id, rf_write, rf_value, rf_read
    );

endinterface

// File: rtl/operand_fetch.sv
// Operand fetch FSM sharing one register-file port between operand reads and
// writebacks, with a bounded writeback streak so a pending read cannot starve.
//
// state   | meaning
// IDLE    | accepting a request; writebacks always granted
// READ_A  | reading rs1 unless a writeback takes the port
// READ_B  | reading rs2 unless a writeback takes the port
// HOLD    | operands presented; writebacks always granted
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int REG_ID_LEN   = CPU_REG_ID_LEN,
    parameter int REG_SIZE     = CPU_REG_SIZE,
    parameter int STARVE_LIMIT = CPU_STARVE_LIMIT
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_fetch_if.slave bus
);

    localparam int SW = streak_width(STARVE_LIMIT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STREAK_ONE = SW'(1);

    fetch_state_t          state;
    logic [SW-1:0]         streak;
    logic [REG_ID_LEN-1:0] rs1_q;
    logic [REG_ID_LEN-1:0] rs2_q;
    logic                  use_rs2_q;
    logic [REG_SIZE-1:0]   op_a_q;
    logic [REG_SIZE-1:0]   op_b_q;

    logic in_read;
    logic wb_take;
    logic rd_cycle;

    assign in_read  = (state == ST_READ_A) || (state == ST_READ_B);
    assign wb_take  = bus.wb_valid && (streak < STREAK_MAX);
    assign rd_cycle = rst_n && in_read && !wb_take;

    // Reset gates the handshakes combinationally so nothing is granted while held.
    assign bus.req_ready = rst_n && (state == ST_IDLE);
    assign bus.wb_ready  = rst_n && (!in_read || wb_take);
    assign bus.rf_write  = bus.wb_valid && bus.wb_ready;
    assign bus.rf_read   = rd_cycle;
    assign bus.rf_value  = bus.rf_write ? bus.wb_value : '0;
    assign bus.op_valid  = (state == ST_HOLD);
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;

    always_comb begin
        bus.rf_id = '0;
        if (bus.rf_write) begin
            bus.rf_id = bus.wb_id;
        end else if (rd_cycle) begin
            bus.rf_id = (state == ST_READ_A) ? rs1_q : rs2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            streak    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_rs2_q <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    streak <= '0;
                    if (bus.req_valid) begin
                        rs1_q     <= bus.req_rs1;
                        rs2_q     <= bus.req_rs2;
                        use_rs2_q <= bus.req_use_rs2;
                        state     <= ST_READ_A;
                    end
                end
                ST_READ_A: begin
                    if (wb_take) begin
                        streak <= streak + STREAK_ONE;
                    end else begin
                        streak <= '0;
                        op_a_q <= bus.rf_out;
                        if (use_rs2_q) begin
                            state <= ST_READ_B;
                        end else begin
                            op_b_q <= '0;
                            state  <= ST_HOLD;
                        end
                    end
                end
                ST_READ_B: begin
                    if (wb_take) begin
                        streak <= streak + STREAK_ONE;
                    end else begin
                        streak <= '0;
                        op_b_q <= bus.rf_out;
                        state  <= ST_HOLD;
                    end
                end
                default: begin
                    streak <= '0;
                    if (bus.op_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
